gate_checker: RTL
=================

GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 20: cycles each input vector is held before the response is sampled; legal range 1..255.
REQ-002 Parameter EXPECTED, default 4'b1000: expected truth table; bit index {B,A} gives the expected Gate_Out (4'b1000 = AND).
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to run one check sequence; sampled only in IDLE.
REQ-006 Gate_Out  input  1  response of the 2-input gate under test.
REQ-007 Input_A  output  1  operand A driven to the gate under test.
REQ-008 Input_B  output  1  operand B driven to the gate under test.
REQ-009 Busy  output  1  high while a sequence is in progress.
REQ-010 Done  output  1  one-cycle pulse marking sequence completion.
REQ-011 Pass  output  1  high when the last completed sequence had zero mismatches.
REQ-012 Error_Count  output  3  number of mismatches in the current or last sequence (0..4).
REQ-013 Fail_Mask  output  4  bit k set when vector k ({B,A}=k) mismatched.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, DONE; unused encodings SHALL return to IDLE.
REQ-015 IDLE: Input_A=Input_B=0, Busy=0; Start=1 at edge E0 -> HOLD, vector index k=0, hold counter=0, Error_Count, Fail_Mask and Pass cleared, Busy=1.
REQ-016 Vector order SHALL be k=0,1,2,3 with Input_A=k[0], Input_B=k[1] (00, 10, 01, 11 as A,B).
REQ-017 Each vector SHALL be driven for exactly SETTLE_CYCLES cycles; Gate_Out SHALL be sampled at edge E0+(k+1)*SETTLE_CYCLES.
REQ-018 At each sample, Gate_Out != EXPECTED[k] SHALL set Fail_Mask[k] and increment Error_Count in the same edge.
REQ-019 After sampling k=3 (edge E0+4*SETTLE_CYCLES): state DONE, Done=1 for exactly one cycle, Busy=0, Input_A=Input_B=0, Pass=(final Error_Count==0).
REQ-020 DONE SHALL transition to IDLE unconditionally on the next edge; Start seen in DONE or HOLD SHALL be ignored.
REQ-021 Pass, Error_Count and Fail_Mask SHALL hold their values until the next accepted Start or Reset.
REQ-022 Error_Count SHALL never wrap; maximum value 4.
REQ-023 Hold counter width SHALL be 8 bits; SETTLE_CYCLES=1 SHALL yield one sample per cycle with no skipped vectors.

Reset
REQ-024 Reset=1 at an edge SHALL force IDLE, Input_A=0, Input_B=0, Busy=0, Done=0, Pass=0, Error_Count=0, Fail_Mask=0000.
REQ-025 Reset SHALL take priority over Start and over any in-progress sample in the same edge.
REQ-026 Reset mid-sequence SHALL abort without a Done pulse; a later Start SHALL run a full fresh sequence.

Configuration
REQ-027 Macro GATE_CHECKER_STOP_ON_FAIL_EN defined: the first mismatch SHALL end the sequence at that sample edge (DONE next, Done pulse, remaining vectors not applied, Error_Count=1, Pass=0).
REQ-028 Macro undefined: all four vectors SHALL always be applied regardless of mismatches.

Verification
REQ-029 Correct AND model, SETTLE_CYCLES=20, Start at E0 -> Done at E0+80 edge, Pass=1, Error_Count=0, Fail_Mask=0000.
REQ-030 Gate_Out tied 0 -> Error_Count=1, Fail_Mask=1000, Pass=0.
REQ-031 Gate_Out tied 1, macro undefined -> Error_Count=3, Fail_Mask=0111; macro defined -> Done at E0+20 edge, Error_Count=1, Fail_Mask=0001.
REQ-032 Reset asserted at E0+40 -> all outputs at reset values next cycle, no Done; then Start -> full pass with AND model.
REQ-033 Start pulsed at E0+10 during HOLD -> ignored, single Done at E0+80; Start in DONE cycle ignored.
REQ-034 EXPECTED=4'b1110 with OR model, SETTLE_CYCLES=1 -> Done at E0+4 edge, Pass=1.

Source files
------------

// File: rtl/gate_checker.sv
// Sequences the four {B,A} vectors into a 2-input gate and compares each settled response
// against a parameterised truth table. Optional early exit: GATE_CHECKER_STOP_ON_FAIL_EN.
module gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter logic [3:0]  EXPECTED      = 4'b1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Gate_Out,
  output logic       Input_A,
  output logic       Input_B,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [2:0] Error_Count,
  output logic [3:0] Fail_Mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic       miss;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 8'd0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    miss    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = HOLD;
          vec_d   = 2'd0;
          cnt_d   = 8'd0;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == LAST_CNT) begin
          // Response has settled for the full window: sample and advance.
          cnt_d = 8'd0;
          miss  = (Gate_Out != EXPECTED[vec_q]);
          if (miss) begin
            mask_d[vec_q] = 1'b1;
            if (err_q != 3'd4) err_d = err_q + 3'd1;
          end
          if ((vec_q == 2'd3) || (STOP_ON_FAIL && miss)) begin
            state_d = DONE;
            pass_d  = (err_d == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy        = (state_q == HOLD);
  assign Done        = (state_q == DONE);
  assign Input_A     = Busy & vec_q[0];
  assign Input_B     = Busy & vec_q[1];
  assign Pass        = pass_q;
  assign Error_Count = err_q;
  assign Fail_Mask   = mask_q;

endmodule
